// File: rtl/mux_pipeline_hs.sv
// mux_pipeline_hs
//   Streaming N:1 pipelined multiplexer tree with valid/ready flow control.
//   Every tree level registers its data together with the select bits that
//   later levels still need, a valid flag and (optionally) an out-of-range
//   flag, so each beat carries its own selection through the pipe. The whole
//   pipe advances together whenever the output is empty or being accepted.
//   Latency is L cycles, where L is the number of tree levels.
//
// Parameters
//   WIDTH        bits per input lane
//   INPUT_COUNT  number of lanes (>= 1)
//   MUX_SIZE     fan-in of one tree unit (power of two >= 2)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   pipe accepts a beat this cycle
//   sel        lane index for this beat
//   in         lanes, lane i at [i*WIDTH +: WIDTH]
//   out_valid  output beat present
//   out_ready  consumer accepts the output beat
//   out        selected lane
//   out_err    beat had sel >= INPUT_COUNT (range-check builds only)
//
// Build option
//   MUX_PIPELINE_HS_RANGE_CHECK_EN  when defined, level 0 flags sel values
//   beyond the last lane; the flag travels with the beat and forces out=0,
//   out_err=1. When undefined out_err is tied low and no flag is stored.

module mux_pipeline_hs #(
    parameter int WIDTH       = 4,
    parameter int INPUT_COUNT = 10,
    parameter int MUX_SIZE    = 4,
    localparam int SW         = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SW-1:0]                sel,
    input  logic [WIDTH*INPUT_COUNT-1:0] in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out,
    output logic                         out_err
);

    function automatic int calc_depth();
        int depth;
        int cap;
        depth = 1;
        cap   = MUX_SIZE;
        while (cap < INPUT_COUNT) begin
            cap   = cap * MUX_SIZE;
            depth = depth + 1;
        end
        return depth;
    endfunction

    localparam int B     = $clog2(MUX_SIZE);
    localparam int L     = calc_depth();
    localparam int SEL_W = L * B;

    // Number of units at level d: the lane count divided by MUX_SIZE, rounded
    // up, once per level.
    function automatic int units_at(input int d);
        int n;
        n = INPUT_COUNT;
        for (int i = 0; i <= d; i++) begin
            n = (n + MUX_SIZE - 1) / MUX_SIZE;
        end
        return n;
    endfunction

    function automatic int inputs_at(input int d);
        return (d == 0) ? INPUT_COUNT : units_at(d - 1);
    endfunction

    logic             en;
    logic [SEL_W-1:0] sel_ext;

    // A bubble at the output never blocks: out_valid=0 keeps the pipe moving.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // A single-lane instance ignores sel entirely.
    always_comb begin
        sel_ext = (INPUT_COUNT == 1) ? '0 : SEL_W'(sel);
    end

    for (genvar d = 0; d < L; d++) begin : g_lvl
        localparam int NI = inputs_at(d);
        localparam int NU = units_at(d);
        localparam int CW = (L - d) * B;

        logic [NI*WIDTH-1:0]          src;
        logic [CW-1:0]                cur_sel;
        logic                         src_valid;
        logic [NU*MUX_SIZE*WIDTH-1:0] src_pad;
        logic [NU*WIDTH-1:0]          nxt;
        logic [NU*WIDTH-1:0]          data_q;
        logic                         valid_q;
`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
        logic                         src_err;
        logic                         err_q;
`endif

        if (d == 0) begin : g_first
            assign src       = in;
            assign cur_sel   = sel_ext;
            assign src_valid = in_valid;
`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
            assign src_err   = (INPUT_COUNT > 1) && (int'(sel) >= INPUT_COUNT);
`endif
        end else begin : g_next
            assign src       = g_lvl[d-1].data_q;
            assign cur_sel   = g_lvl[d-1].g_rem.sel_q;
            assign src_valid = g_lvl[d-1].valid_q;
`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
            assign src_err   = g_lvl[d-1].err_q;
`endif
        end

        // Inputs are zero-padded to a whole number of units, so a short unit
        // selected past its last input yields zero data.
        always_comb begin
            src_pad               = '0;
            src_pad[NI*WIDTH-1:0] = src;
            nxt                   = '0;
            for (int u = 0; u < NU; u++) begin
                nxt[u*WIDTH +: WIDTH] =
                    src_pad[(u*MUX_SIZE + int'(cur_sel[B-1:0]))*WIDTH +: WIDTH];
            end
        end

        // Data loads on every advance, valid or not; only valid marks it useful.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (en) begin
                data_q  <= nxt;
                valid_q <= src_valid;
            end
        end

`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
        always_ff @(posedge clk) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (en) begin
                err_q <= src_err;
            end
        end
`endif

        // Select bits still needed by later levels ride along with the data.
        if (d < L - 1) begin : g_rem
            logic [CW-B-1:0] sel_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_q <= '0;
                end else if (en) begin
                    sel_q <= cur_sel[CW-1:B];
                end
            end
        end
    end

    assign out_valid = g_lvl[L-1].valid_q;

`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
    assign out_err = g_lvl[L-1].err_q;
    assign out     = g_lvl[L-1].err_q ? '0 : g_lvl[L-1].data_q;
`else
    assign out_err = 1'b0;
    assign out     = g_lvl[L-1].data_q;
`endif

endmodule

// File: tb/tb_mux_pipeline_hs.sv
// tb_mux_pipeline_hs
//   Drives four configurations of mux_pipeline_hs from one shared stimulus
//   stream and checks each against an in-order beat queue:
//     dut 0: WIDTH=4, INPUT_COUNT=10, MUX_SIZE=4   (L=2)
//     dut 1: WIDTH=4, INPUT_COUNT=10, MUX_SIZE=2   (L=4)
//     dut 2: WIDTH=4, INPUT_COUNT=1,  MUX_SIZE=4   (L=1)
//     dut 3: WIDTH=4, INPUT_COUNT=16, MUX_SIZE=16  (L=1)

module tb_mux_pipeline_hs;

    localparam int LAT [4] = '{2, 4, 1, 1};
    localparam int ICN [4] = '{10, 10, 1, 16};
`ifdef MUX_PIPELINE_HS_RANGE_CHECK_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  sel;
    logic [3:0]  lanes [16];
    logic [63:0] in_bus;

    logic        ov [4];
    logic        ir [4];
    logic        oe [4];
    logic [3:0]  od [4];

    always #5 clk = ~clk;

    always_comb begin
        in_bus = '0;
        for (int i = 0; i < 16; i++) in_bus[i*4 +: 4] = lanes[i];
    end

    mux_pipeline_hs #(.WIDTH(4), .INPUT_COUNT(10), .MUX_SIZE(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .sel(sel),
        .in(in_bus[39:0]), .out_valid(ov[0]), .out_ready(out_ready), .out(od[0]), .out_err(oe[0]));

    mux_pipeline_hs #(.WIDTH(4), .INPUT_COUNT(10), .MUX_SIZE(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .sel(sel),
        .in(in_bus[39:0]), .out_valid(ov[1]), .out_ready(out_ready), .out(od[1]), .out_err(oe[1]));

    mux_pipeline_hs #(.WIDTH(4), .INPUT_COUNT(1), .MUX_SIZE(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .sel(sel[0]),
        .in(in_bus[3:0]), .out_valid(ov[2]), .out_ready(out_ready), .out(od[2]), .out_err(oe[2]));

    mux_pipeline_hs #(.WIDTH(4), .INPUT_COUNT(16), .MUX_SIZE(16)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .sel(sel),
        .in(in_bus), .out_valid(ov[3]), .out_ready(out_ready), .out(od[3]), .out_err(oe[3]));

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_stall = 0;
    bit rst_seen = 1'b0;

    logic [3:0] qd [4][64];
    int         qe [4][64];
    int         qa [4][64];
    int         wp [4];
    int         rp [4];
    bit         fchk [4];
    int         cidx;

    logic [3:0] deliv [512];
    logic       derr [512];
    int         dcyc [512];
    int         nd = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, k, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_data(input int k, input int s);
        if (ICN[k] == 1) return lanes[0];
        if (s < ICN[k]) return lanes[s];
        return 4'd0;
    endfunction

    function automatic int exp_err(input int k, input int s);
        return (RC == 1 && ICN[k] > 1 && s >= ICN[k]) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_seen) begin
            for (int k = 0; k < 4; k++) begin
                chk("rst_out_valid", k, int'(ov[k]), 0);
                chk("rst_out", k, int'(od[k]), 0);
                chk("rst_out_err", k, int'(oe[k]), 0);
                chk("rst_in_ready", k, int'(ir[k]), 1);
            end
        end
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                wp[k] = 0;
                rp[k] = 0;
                fchk[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("in_ready", k, int'(ir[k]), int'(!ov[k] || out_ready));
                if (ov[k]) begin
                    chk("beat_pending", k, int'(wp[k] != rp[k]), 1);
                    if (wp[k] != rp[k]) begin
                        cidx = rp[k] % 64;
                        chk("out", k, int'(od[k]), int'(qd[k][cidx]));
                        chk("out_err", k, int'(oe[k]), qe[k][cidx]);
                        if (!fchk[k] && last_stall < qa[k][cidx])
                            chk("latency", k, cyc - qa[k][cidx], LAT[k]);
                        fchk[k] = 1'b1;
                        if (out_ready) begin
                            rp[k] = rp[k] + 1;
                            fchk[k] = 1'b0;
                        end
                    end
                end
                if (in_valid && ir[k]) begin
                    cidx = wp[k] % 64;
                    qd[k][cidx] = exp_data(k, int'(sel));
                    qe[k][cidx] = exp_err(k, int'(sel));
                    qa[k][cidx] = cyc;
                    wp[k] = wp[k] + 1;
                end
            end
            if (ov[0] && out_ready) begin
                deliv[nd % 512] = od[0];
                derr[nd % 512]  = oe[0];
                dcyc[nd % 512]  = cyc;
                nd = nd + 1;
            end
            if (!out_ready) last_stall = cyc;
        end
        rst_seen = rst;
    end

    task automatic drive(input bit v, input int s, input bit r);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = 4'(s);
        out_ready = r;
    endtask

    int  base;
    int  idx;
    bit  acc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        sel = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) lanes[i] = 4'(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset held three cycles in the middle of a stream
        for (int i = 0; i < 4; i++) drive(1'b1, i + 2, 1'b1);
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) drive(1'b0, 0, 1'b1);

        // streaming 0..9, no back-pressure
        base = nd;
        for (int i = 0; i < 10; i++) drive(1'b1, i, 1'b1);
        repeat (6) drive(1'b0, 0, 1'b1);
        chk("stream_count", 0, nd - base, 10);
        for (int i = 0; i < 10; i++) begin
            chk("stream_data", 0, int'(deliv[(base + i) % 512]), i);
            chk("stream_gap", 0, dcyc[(base + i) % 512] - dcyc[base % 512], i);
        end

        // back-pressure in stream cycles 4..7, producer holds beats until taken
        base = nd;
        idx = 0;
        drive(1'b1, 0, 1'b1);
        for (int c = 1; c < 40 && idx < 10; c++) begin
            @(negedge clk);
            acc = in_valid && ir[0];
            @(posedge clk);
            #1;
            if (acc) idx++;
            in_valid  = (idx < 10);
            sel       = 4'(idx);
            out_ready = !(c >= 4 && c <= 7);
        end
        chk("bp_sent", 0, idx, 10);
        repeat (8) drive(1'b0, 0, 1'b1);
        chk("bp_count", 0, nd - base, 10);
        for (int i = 0; i < 10; i++)
            chk("bp_data", 0, int'(deliv[(base + i) % 512]), i);

        // bubbles with the consumer stalling after the first output
        base = nd;
        drive(1'b1, 5, 1'b1);
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 7, 1'b1);
        drive(1'b0, 0, 1'b1);
        repeat (4) drive(1'b0, 0, 1'b0);
        repeat (6) drive(1'b0, 0, 1'b1);
        chk("bubble_count", 0, nd - base, 2);
        chk("bubble_first", 0, int'(deliv[base % 512]), 5);
        chk("bubble_second", 0, int'(deliv[(base + 1) % 512]), 7);

        // out-of-range select followed by an in-range one
        base = nd;
        drive(1'b1, 12, 1'b1);
        drive(1'b1, 3, 1'b1);
        repeat (6) drive(1'b0, 0, 1'b1);
        chk("range_count", 0, nd - base, 2);
        chk("range_out", 0, int'(deliv[base % 512]), 0);
        chk("range_err", 0, int'(derr[base % 512]), RC);
        chk("range_next_out", 0, int'(deliv[(base + 1) % 512]), 3);
        chk("range_next_err", 0, int'(derr[(base + 1) % 512]), 0);

        // random sel / data / flow control with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 16; i++) lanes[i] = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = (c >= 200 && c < 203);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) drive(1'b0, 0, 1'b1);
        for (int k = 0; k < 4; k++) chk("drained", k, wp[k] - rp[k], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
